// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and counter sizing.
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } div_state_e;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int div_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: produces one quotient bit per call.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] a_next
);

  logic [WIDTH:0] shifted;

  always_comb begin
    shifted = {p[WIDTH-1:0], a[WIDTH-1]};
    p_next  = shifted;
    a_next  = {a[WIDTH-2:0], 1'b0};
    if (shifted >= {1'b0, divisor}) begin
      p_next = shifted - {1'b0, divisor};
      a_next = {a[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq_param.sv
// Parametrised sequential restoring divider with start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division).
module div_seq_param
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CNT_W = div_cnt_w(WIDTH);

  // Handshake: start is taken only on an edge where ready=1 (IDLE); done pulses
  // for one cycle in DONE and q/r/div_by_zero hold until the next done.
  div_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] a, d;
  logic [WIDTH:0]   p_step;
  logic [WIDTH-1:0] a_step;
  logic [WIDTH-1:0] dd_mag, dv_mag, q_fin, r_fin;

  div_step #(.WIDTH(WIDTH)) u_step (
    .p      (p),
    .a      (a),
    .divisor(d),
    .p_next (p_step),
    .a_next (a_step)
  );

`ifdef DIV_SIGNED_EN
  logic neg_q, neg_r;

  assign dd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dv_mag = divisor[WIDTH-1] ? -divisor : divisor;
  assign q_fin  = neg_q ? -a : a;
  assign r_fin  = neg_r ? -p[WIDTH-1:0] : p[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && start) begin
      neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r <= dividend[WIDTH-1];
    end
  end
`else
  assign dd_mag = dividend;
  assign dv_mag = divisor;
  assign q_fin  = a;
  assign r_fin  = p[WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? DONE : CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // CALC spends WIDTH cycles stepping, then one more cycle publishing results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      p           <= '0;
      a           <= '0;
      d           <= '0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              q           <= '1;
              r           <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              a   <= dd_mag;
              d   <= dv_mag;
              p   <= '0;
              cnt <= CNT_W'(WIDTH);
            end
          end
        end
        CALC: begin
          if (cnt != '0) begin
            p   <= p_step;
            a   <= a_step;
            cnt <= cnt - CNT_W'(1);
          end else begin
            q           <= q_fin;
            r           <= r_fin;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

endmodule
